// File: rtl/option_streamer.sv
// option_streamer: circular option FIFO feeding the nonogram solver.
// Loads tagged line-index / option words, then streams them in passes.
// Re-enqueues solver-flagged options and reports per-line counts per pass.
// Ports:
//   clk, rst           clock, async active-high reset
//   load_valid/ready   load handshake; load_word + load_is_index tag
//   load_done          pulse ending the load phase
//   put_back_to_FIFO   verdict for the option emitted the previous cycle
//   solved             solver finished; stop streaming
//   option, valid_op   streamed word and its valid flag
//   started            first word of the first pass
//   old_options_amnt   per-line option counts for the current pass
//   pass_done          one-cycle pulse at the end of each pass
//   stuck, done        sticky status flags
module option_streamer #(
   parameter int SIZE  = 3,
   parameter int DEPTH = 64,
   parameter int CNT_W = 7
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [SIZE-1:0]                load_word,
   input  logic                           load_is_index,
   input  logic                           load_done,
   input  logic                           put_back_to_FIFO,
   input  logic                           solved,
   output logic [SIZE-1:0]                option,
   output logic                           valid_op,
   output logic                           started,
   output logic [2*SIZE-1:0][CNT_W-1:0]   old_options_amnt,
   output logic                           pass_done,
   output logic                           stuck,
   output logic                           done
);

   localparam int AW    = $clog2(DEPTH);
   localparam int NL    = 2 * SIZE;
   localparam int SUM_W = CNT_W + SIZE;
   localparam logic [SIZE-1:0] NL_W  = SIZE'(NL);
   localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_PASS_END,
      S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [SIZE:0]                 r_mem [DEPTH];
   logic [AW-1:0]                 r_wr_ptr, r_rd_ptr;
   logic [AW:0]                   r_count, r_pass_len, r_pop_cnt;
   logic [SIZE-1:0]               r_cur_line;
   logic                          r_idx_seen;
   logic [NL-1:0][CNT_W-1:0]      r_new_cnt, r_old_cnt;
   // word on the output this cycle
   logic [SIZE-1:0]               r_opt, r_opt_line;
   logic                          r_opt_tag, r_valid;
   // word emitted one cycle earlier, awaiting its verdict
   logic [SIZE-1:0]               r_wb_word, r_wb_line;
   logic                          r_wb_tag, r_wb_valid;
   logic                          r_first, r_started, r_stuck, r_done;

   logic [SIZE:0]                 w_head, w_wr_data;
   logic [SIZE-1:0]               w_head_line;
   logic                          w_full, w_load_acc, w_idx_ok;
   logic                          w_ld_wr, w_ld_opt;
   logic                          w_pop, w_wb_en, w_wb_opt, w_wr;
   logic                          w_active, w_pass_last;
   logic [SUM_W-1:0]              w_new_sum, w_old_sum;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_head      = r_mem[r_rd_ptr];
   assign w_full      = (r_count == FULL);
   assign load_ready  = (r_state == S_LOAD) && !w_full && !load_done;
   assign w_load_acc  = load_valid && load_ready;
   assign w_idx_ok    = load_is_index && (load_word < NL_W);
   // options are kept only once a valid line index has been seen
   assign w_ld_opt    = w_load_acc && !load_is_index && r_idx_seen;
   assign w_ld_wr     = (w_load_acc && w_idx_ok) || w_ld_opt;
   assign w_pass_last = (r_pop_cnt == r_pass_len);
   assign w_pop       = (r_state == S_RUN) && !w_pass_last && !solved;
   assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
   // index words always survive; options only on a put-back verdict
   assign w_wb_en     = w_active && r_wb_valid && !solved &&
                        (r_wb_tag || put_back_to_FIFO);
   assign w_wb_opt    = w_wb_en && !r_wb_tag;
   assign w_wr        = w_ld_wr || w_wb_en;
   assign w_wr_data   = (r_state == S_LOAD) ?
                        {load_is_index, load_word} :
                        {r_wb_tag, r_wb_word};
   assign w_head_line = w_head[SIZE] ? w_head[SIZE-1:0] : r_cur_line;

   always_comb begin
      w_new_sum = '0;
      w_old_sum = '0;
      for (int i = 0; i < NL; i++) begin
         w_new_sum = w_new_sum + SUM_W'(r_new_cnt[i]);
         w_old_sum = w_old_sum + SUM_W'(r_old_cnt[i]);
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_LOAD: begin
            if (load_done)
               w_next = (r_count == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (solved)
               w_next = S_DONE;
            else if (w_pass_last)
               w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_next = solved ? S_DONE : S_PASS_END;
         end
         S_PASS_END: begin
            if (solved || w_new_sum == w_old_sum || w_new_sum == '0)
               w_next = S_DONE;
            else
               w_next = S_RUN;
         end
         S_DONE: begin
            w_next = S_DONE;
         end
         default: begin
            w_next = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= w_wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_LOAD;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_pass_len <= '0;
         r_pop_cnt  <= '0;
         r_cur_line <= '0;
         r_idx_seen <= 1'b0;
         r_new_cnt  <= '0;
         r_old_cnt  <= '0;
         r_opt      <= '0;
         r_opt_line <= '0;
         r_opt_tag  <= 1'b0;
         r_valid    <= 1'b0;
         r_wb_word  <= '0;
         r_wb_line  <= '0;
         r_wb_tag   <= 1'b0;
         r_wb_valid <= 1'b0;
         r_first    <= 1'b0;
         r_started  <= 1'b0;
         r_stuck    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);

         r_valid   <= w_pop;
         r_started <= w_pop && r_first && (r_pop_cnt == '0);
         if (w_pop) begin
            r_opt      <= w_head[SIZE-1:0];
            r_opt_tag  <= w_head[SIZE];
            r_opt_line <= w_head_line;
            r_pop_cnt  <= r_pop_cnt + 1'b1;
            if (w_head[SIZE])
               r_cur_line <= w_head[SIZE-1:0];
         end
         r_wb_valid <= r_valid;
         r_wb_word  <= r_opt;
         r_wb_tag   <= r_opt_tag;
         r_wb_line  <= r_opt_line;

         // an out-of-range index orphans the options that follow it
         if (w_load_acc && load_is_index) begin
            r_idx_seen <= w_idx_ok;
            if (w_idx_ok)
               r_cur_line <= load_word;
         end

         if (w_ld_opt)
            r_new_cnt[r_cur_line] <= sat_inc(r_new_cnt[r_cur_line]);
         else if (w_wb_opt)
            r_new_cnt[r_wb_line] <= sat_inc(r_new_cnt[r_wb_line]);

         if (r_state == S_LOAD && load_done) begin
            r_old_cnt  <= r_new_cnt;
            r_new_cnt  <= '0;
            r_pass_len <= r_count;
            r_pop_cnt  <= '0;
            r_cur_line <= '0;
            r_first    <= 1'b1;
            if (r_count == '0)
               r_done <= 1'b1;
         end

         if (r_state == S_PASS_END && !solved) begin
            r_first <= 1'b0;
            if (w_new_sum == w_old_sum) begin
               r_stuck <= 1'b1;
               r_done  <= 1'b1;
            end else if (w_new_sum == '0) begin
               r_done <= 1'b1;
            end else begin
               r_old_cnt  <= r_new_cnt;
               r_new_cnt  <= '0;
               r_pass_len <= r_count;
               r_pop_cnt  <= '0;
            end
         end

         if (solved && r_state != S_LOAD && r_state != S_DONE)
            r_done <= 1'b1;
      end
   end

   assign option           = r_opt;
   assign valid_op         = r_valid;
   assign started          = r_started;
   assign old_options_amnt = r_old_cnt;
   assign pass_done        = (r_state == S_PASS_END);
   assign stuck            = r_stuck;
   assign done             = r_done;

endmodule

// File: tb/tb_option_streamer.sv
// tb_option_streamer: directed bench with a queue-level pass model.
// Covers load, passes, stuck, solved, full FIFO and async reset.
module tb_option_streamer;

   localparam int SIZE  = 3;
   localparam int CNT_W = 7;
   localparam int NL    = 2 * SIZE;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                         load_valid, load_ready, load_is_index;
   logic                         load_done, put_back, solved;
   logic [SIZE-1:0]              load_word, option;
   logic                         valid_op, started, pass_done, stuck, done;
   logic [NL-1:0][CNT_W-1:0]     old_amnt;

   logic                         b_load_valid, b_load_ready, b_load_is_index;
   logic                         b_load_done;
   logic [SIZE-1:0]              b_load_word, b_option;
   logic                         b_valid_op, b_started, b_pass_done;
   logic                         b_stuck, b_done;
   logic [NL-1:0][CNT_W-1:0]     b_old_amnt;
   logic                         b_zero;

   option_streamer #(.SIZE(SIZE), .DEPTH(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_word(load_word), .load_is_index(load_is_index),
      .load_done(load_done), .put_back_to_FIFO(put_back),
      .solved(solved), .option(option), .valid_op(valid_op),
      .started(started), .old_options_amnt(old_amnt),
      .pass_done(pass_done), .stuck(stuck), .done(done)
   );

   option_streamer #(.SIZE(SIZE), .DEPTH(16), .CNT_W(CNT_W)) dut16 (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_ready(b_load_ready),
      .load_word(b_load_word), .load_is_index(b_load_is_index),
      .load_done(b_load_done), .put_back_to_FIFO(b_zero),
      .solved(b_zero), .option(b_option), .valid_op(b_valid_op),
      .started(b_started), .old_options_amnt(b_old_amnt),
      .pass_done(b_pass_done), .stuck(b_stuck), .done(b_done)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic       tag;
      logic [2:0] word;
      logic [2:0] line;
   } ent_t;

   ent_t mq[$];
   bit   m_stuck, m_done;

   // bit 3 = index tag
   logic [3:0] scen [18] = '{
      4'b1000, 4'b0110, 4'b0011,
      4'b1001, 4'b0100, 4'b0010, 4'b0001,
      4'b1010, 4'b0101,
      4'b1011, 4'b0101,
      4'b1100, 4'b0110, 4'b0011,
      4'b1101, 4'b0100, 4'b0010, 4'b0001
   };

   int lit_load [NL] = '{2, 3, 1, 1, 2, 3};
   int lit_p2   [NL] = '{2, 3, 0, 0, 1, 1};
   int lit_d16  [NL] = '{2, 3, 1, 1, 2, 1};

   // mode 0: drop all, 1: test-plan selection, 2: keep all
   function automatic bit keep(input int mode, input ent_t e);
      case (mode)
         1: return (e.line == 0) || (e.line == 1) ||
                   (e.line == 4 && e.word == 3'b110) ||
                   (e.line == 5 && e.word == 3'b001);
         2: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int opt_total(input ent_t q[$]);
      int n = 0;
      foreach (q[i]) if (!q[i].tag) n++;
      return n;
   endfunction

   task automatic chk_old(input string name, input int e [NL]);
      for (int i = 0; i < NL; i++)
         chk($sformatf("%s_line%0d", name, i), old_amnt[i], e[i]);
   endtask

   task automatic chk_model_old(input string name);
      int c [NL];
      for (int i = 0; i < NL; i++) c[i] = 0;
      foreach (mq[i]) if (!mq[i].tag) c[mq[i].line]++;
      chk_old(name, c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      load_valid = 0; load_done = 0; load_is_index = 0; load_word = '0;
      put_back = 0; solved = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_main();
      bit seen = 0;
      logic [2:0] ln = '0;
      ent_t e;
      mq.delete();
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         load_valid    = 1'b1;
         load_is_index = scen[i][3];
         load_word     = scen[i][2:0];
         if (scen[i][3]) begin
            seen = 1; ln = scen[i][2:0];
         end
         e.tag = scen[i][3]; e.word = scen[i][2:0]; e.line = ln;
         if (seen) mq.push_back(e);
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_done  = 1'b1;
      @(negedge clk);
      load_done  = 1'b0;
   endtask

   // streams one pass, acting as the solver; solve_at >= 0 raises solved
   task automatic run_pass(input int mode, input bit first,
                           input int solve_at, output int emitted);
      ent_t nq[$];
      ent_t cur, pe;
      int   idx = 0;
      bit   pv = 0, fin = 0, is_v;
      for (int c = 0; c < 100 && !fin; c++) begin
         @(negedge clk);
         is_v = valid_op;
         if (idx > 0 && idx < mq.size())
            chk("back_to_back", valid_op, 1);
         if (is_v) begin
            if (idx < mq.size()) begin
               cur = mq[idx];
               chk("option_word", option, cur.word);
               chk("started", started, first && idx == 0);
               if (cur.tag || keep(mode, cur)) nq.push_back(cur);
            end else begin
               chk("extra_word", idx, mq.size());
            end
            idx++;
         end else begin
            chk("started_idle", started, 0);
         end
         put_back = pv && !pe.tag && keep(mode, pe);
         pv = is_v;
         pe = cur;
         if (solve_at >= 0 && is_v && idx == solve_at) begin
            solved = 1'b1;
            fin = 1;
         end
         if (pass_done) fin = 1;
      end
      put_back = 1'b0;
      chk("pass_end_reached", fin, 1);
      emitted = idx;
      if (solve_at < 0) begin
         m_stuck = (opt_total(nq) == opt_total(mq));
         m_done  = m_stuck || (opt_total(nq) == 0);
         mq = nq;
      end
   endtask

   task automatic boundary(input string name);
      @(negedge clk);
      chk({name, "_pulse_one_cycle"}, pass_done, 0);
      chk({name, "_stuck"}, stuck, m_stuck);
      chk({name, "_done"}, done, m_done);
      if (!m_done) chk_model_old({name, "_model_old"});
   endtask

   task automatic quiet(input string name);
      bit any = 0;
      repeat (20) begin
         @(negedge clk);
         any |= valid_op | pass_done;
      end
      chk(name, any, 0);
   endtask

   task automatic load_d16();
      int acc = 0;
      bit rdy;
      for (int i = -1; i < 17; i++) begin
         @(negedge clk);
         b_load_valid = 1'b1;
         if (i < 0) begin
            b_load_is_index = 1'b0;
            b_load_word     = 3'b111;
         end else begin
            b_load_is_index = scen[i][3];
            b_load_word     = scen[i][2:0];
         end
         #1;
         rdy = b_load_ready;
         if (rdy) acc++;
      end
      chk("d16_ready_when_full", rdy, 0);
      chk("d16_accepted", acc, 17);
      @(negedge clk);
      b_load_valid = 1'b0;
      b_load_done  = 1'b1;
      @(negedge clk);
      b_load_done  = 1'b0;
      for (int i = 0; i < NL; i++)
         chk($sformatf("d16_old_line%0d", i), b_old_amnt[i], lit_d16[i]);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      load_valid = 0; load_done = 0; load_is_index = 0; load_word = '0;
      put_back = 0; solved = 0;
      b_load_valid = 0; b_load_done = 0; b_load_is_index = 0;
      b_load_word = '0; b_zero = 0;
      @(negedge clk);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_valid_op", valid_op, 0);
      chk("rst_done", done, 0);
      chk("rst_old", old_amnt, 0);
      @(negedge clk);
      rst = 1'b0;

      load_d16();

      // scenario A: selective pass, then keep-all pass gets stuck
      load_main();
      chk_model_old("load_model");
      chk_old("load_lit", lit_load);
      run_pass(1, 1, -1, n);
      chk("pass1_len", n, 18);
      boundary("p1");
      chk_old("p2_lit", lit_p2);
      run_pass(2, 0, -1, n);
      chk("pass2_len", n, 13);
      boundary("p2");
      chk("stuck_set", stuck, 1);
      quiet("no_restream_after_stuck");

      // scenario B: solved mid pass 2
      do_reset();
      load_main();
      run_pass(1, 1, -1, n);
      boundary("b_p1");
      run_pass(0, 0, 5, n);
      @(negedge clk);
      solved = 1'b0;
      chk("solved_valid_op", valid_op, 0);
      chk("solved_done", done, 1);
      chk("solved_stuck", stuck, 0);
      quiet("no_pass_after_solved");

      // scenario C: reset off-edge mid-run, then replay
      do_reset();
      load_main();
      repeat (6) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid_op", valid_op, 0);
      chk("arst_option", option, 0);
      chk("arst_load_ready", load_ready, 1);
      chk("arst_old", old_amnt, 0);
      chk("arst_started", started, 0);
      @(negedge clk);
      rst = 1'b0;
      load_main();
      chk_old("replay_load_lit", lit_load);
      run_pass(1, 1, -1, n);
      chk("replay_pass1_len", n, 18);
      boundary("replay_p1");
      chk_old("replay_p2_lit", lit_p2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
